// File: rtl/rv32_data_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rv32_data_port_arbiter: shares main-memory port B among NUM_REQ masters  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+

package rv32_types;
  typedef enum logic [2:0] {
    MEM_NOP = 3'd0,
    MEM_LW  = 3'd1,
    MEM_SW  = 3'd2,
    MEM_SH  = 3'd3,
    MEM_SB  = 3'd4
  } mem_op_t;

  typedef struct packed {
    mem_op_t     op;
    logic [31:0] addr;
    logic [31:0] data;
  } memory_request_t;
endpackage

module rv32_data_port_arbiter
  import rv32_types::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  memory_request_t [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]             req_grant,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic                           rsp_err,
  output logic [31:0]                    rsp_data,
  output memory_request_t                mem_request,
  input  logic                           mem_ready,
  input  logic [31:0]                    mem_data
);

  localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] w_compete;
  logic [NUM_REQ-1:0] w_starved;
  logic [NUM_REQ-1:0] w_grant;
  memory_request_t    w_sel;

  logic [3:0]         r_wait_cnt [1:NUM_REQ-1];
  logic [c_PTR_W-1:0] r_rr_ptr;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic               r_rsp_err;
  logic               r_rsp_lw;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_compete
    assign w_compete[i] = req_valid[i] & (req[i].op != MEM_NOP);
  end

  assign w_starved[0] = 1'b0;
  for (genvar i = 1; i < NUM_REQ; i++) begin : g_starve
    assign w_starved[i] = w_compete[i] & (r_wait_cnt[i] >= 4'(MAX_WAIT));
  end

  // Priority: lowest starved index, then the LSU, then round robin over 1..N-1.
  always_comb begin : p_arb
    logic found;
    w_grant = '0;
    found   = 1'b0;
    for (int i = 1; i < NUM_REQ; i++) begin
      if (!found && w_starved[i]) begin
        w_grant[i] = 1'b1;
        found      = 1'b1;
      end
    end
    if (!found && w_compete[0]) begin
      w_grant[0] = 1'b1;
      found      = 1'b1;
    end
    // Two passes realise the wrap: indices above rr_ptr first, then from 1.
    for (int j = 1; j < NUM_REQ; j++) begin
      if (!found && w_compete[j] && (j > int'(r_rr_ptr))) begin
        w_grant[j] = 1'b1;
        found      = 1'b1;
      end
    end
    for (int j = 1; j < NUM_REQ; j++) begin
      if (!found && w_compete[j]) begin
        w_grant[j] = 1'b1;
        found      = 1'b1;
      end
    end
    if (reset) begin
      w_grant = '0;
    end
  end

  always_comb begin : p_mux
    w_sel = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_grant[j]) begin
        w_sel = req[j];
      end
    end
  end

  // An out-of-range request still occupies the slot but never reaches memory.
  always_comb begin : p_mem_req
    mem_request = w_sel;
    if (!mem_ready) begin
      mem_request.op = MEM_NOP;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < NUM_REQ; i++) begin
        r_wait_cnt[i] <= '0;
      end
      r_rr_ptr    <= '0;
      r_rsp_valid <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_lw    <= 1'b0;
    end else begin
      for (int i = 1; i < NUM_REQ; i++) begin
        if (w_compete[i] && !w_grant[i]) begin
          if (r_wait_cnt[i] != 4'hF) begin
            r_wait_cnt[i] <= r_wait_cnt[i] + 4'd1;
          end
        end else begin
          r_wait_cnt[i] <= '0;
        end
      end
      for (int i = 1; i < NUM_REQ; i++) begin
        if (w_grant[i]) begin
          r_rr_ptr <= c_PTR_W'(i);
        end
      end
      r_rsp_valid <= w_grant;
      r_rsp_err   <= (|w_grant) & ~mem_ready;
      r_rsp_lw    <= (|w_grant) & (w_sel.op == MEM_LW);
    end
  end

  assign req_grant = w_grant;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_data  = ((|r_rsp_valid) && r_rsp_lw && !r_rsp_err) ? mem_data : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_rv32_data_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rv32_data_port_arbiter: directed table plus randomized model checking |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_rv32_data_port_arbiter;
  import rv32_types::*;

  localparam int c_N  = 4;
  localparam int c_MW = 4;

  logic                         clk = 1'b0;
  logic                         reset = 1'b1;
  logic [c_N-1:0]               req_valid;
  memory_request_t [c_N-1:0]    req;
  logic [c_N-1:0]               req_grant;
  logic [c_N-1:0]               rsp_valid;
  logic                         rsp_err;
  logic [31:0]                  rsp_data;
  memory_request_t              mem_request;
  logic                         mem_ready;
  logic [31:0]                  mem_data = 32'd0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rv32_data_port_arbiter #(.NUM_REQ(c_N), .MAX_WAIT(c_MW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req(req),
    .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_data(rsp_data), .mem_request(mem_request), .mem_ready(mem_ready),
    .mem_data(mem_data)
  );

  // Simple 4 KiB synchronous memory standing in for port B.
  logic [31:0] mem_arr [0:1023];
  assign mem_ready = (mem_request.addr < 32'h1000);
  always @(posedge clk) begin
    if (mem_request.op == MEM_SW && mem_ready) mem_arr[mem_request.addr[11:2]] <= mem_request.data;
    mem_data <= mem_ready ? mem_arr[mem_request.addr[11:2]] : 32'd0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          rst;
    logic [3:0]  valid;
    mem_op_t     op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  grant;
    mem_op_t     mop;
    logic [3:0]  rv;
    logic        re;
    logic [31:0] rd;
  } vec_t;

  function automatic vec_t mk(bit rst, logic [3:0] v, mem_op_t op, logic [31:0] a, logic [31:0] d,
                              logic [3:0] g, mem_op_t mop, logic [3:0] rv, logic re, logic [31:0] rd);
    vec_t x;
    x.rst = rst; x.valid = v; x.op = op; x.addr = a; x.data = d;
    x.grant = g; x.mop = mop; x.rv = rv; x.re = re; x.rd = rd;
    return x;
  endfunction

  task automatic drive_all(input logic [3:0] v, input mem_op_t op, input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < c_N; i++) begin
      req_valid[i]   = v[i];
      req[i].op      = op;
      req[i].addr    = a;
      req[i].data    = d;
    end
  endtask

  // Reference model state for the randomized phase.
  int              m_wait [c_N];
  int              m_rr;
  logic [c_N-1:0]  prev_grant;
  logic            prev_err;
  logic [31:0]     prev_rd;
  logic [31:0]     mm [int];
  bit              hold [c_N];
  logic            cur_v [c_N];
  memory_request_t cur_r [c_N];

  vec_t tbl [29];
  localparam logic [31:0] c_D = 32'hDEADBEEF;

  initial begin
    for (int k = 0; k < 1024; k++) mem_arr[k] = 32'd0;
    drive_all(4'b1111, MEM_LW, 32'h100, 32'd0);

    // Reset behaviour with every requester asking.
    #12;
    check("reset grant", req_grant, 0);
    check("reset mem op", mem_request.op, MEM_NOP);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_err", rsp_err, 0);
    drive_all(4'b0000, MEM_NOP, 32'd0, 32'd0);
    #1 reset = 1'b0;

    // Write then read back via requester 1.
    tbl[0]  = mk(1, 4'b0010, MEM_SW,  32'h100, c_D, 4'b0010, MEM_SW,  4'b0000, 0, 0);
    tbl[1]  = mk(0, 4'b0010, MEM_LW,  32'h100, 0,   4'b0010, MEM_LW,  4'b0010, 0, 0);
    tbl[2]  = mk(0, 4'b0000, MEM_NOP, 0,       0,   4'b0000, MEM_NOP, 4'b0010, 0, c_D);
    // LSU priority with anti-starvation after MAX_WAIT cycles.
    tbl[3]  = mk(1, 4'b0011, MEM_LW,  32'h100, 0,   4'b0001, MEM_LW,  4'b0000, 0, 0);
    tbl[4]  = mk(0, 4'b0011, MEM_LW,  32'h100, 0,   4'b0001, MEM_LW,  4'b0001, 0, c_D);
    tbl[5]  = mk(0, 4'b0011, MEM_LW,  32'h100, 0,   4'b0001, MEM_LW,  4'b0001, 0, c_D);
    tbl[6]  = mk(0, 4'b0011, MEM_LW,  32'h100, 0,   4'b0001, MEM_LW,  4'b0001, 0, c_D);
    tbl[7]  = mk(0, 4'b0011, MEM_LW,  32'h100, 0,   4'b0010, MEM_LW,  4'b0001, 0, c_D);
    tbl[8]  = mk(0, 4'b0011, MEM_LW,  32'h100, 0,   4'b0001, MEM_LW,  4'b0010, 0, c_D);
    tbl[9]  = mk(0, 4'b0000, MEM_NOP, 0,       0,   4'b0000, MEM_NOP, 4'b0001, 0, c_D);
    // Round robin 1,2,3,1,2,3 with wrap.
    tbl[10] = mk(1, 4'b1110, MEM_LW,  32'h100, 0,   4'b0010, MEM_LW,  4'b0000, 0, 0);
    tbl[11] = mk(0, 4'b1110, MEM_LW,  32'h100, 0,   4'b0100, MEM_LW,  4'b0010, 0, c_D);
    tbl[12] = mk(0, 4'b1110, MEM_LW,  32'h100, 0,   4'b1000, MEM_LW,  4'b0100, 0, c_D);
    tbl[13] = mk(0, 4'b1110, MEM_LW,  32'h100, 0,   4'b0010, MEM_LW,  4'b1000, 0, c_D);
    tbl[14] = mk(0, 4'b1110, MEM_LW,  32'h100, 0,   4'b0100, MEM_LW,  4'b0010, 0, c_D);
    tbl[15] = mk(0, 4'b1110, MEM_LW,  32'h100, 0,   4'b1000, MEM_LW,  4'b0100, 0, c_D);
    tbl[16] = mk(0, 4'b0000, MEM_NOP, 0,       0,   4'b0000, MEM_NOP, 4'b1000, 0, c_D);
    // Out-of-range store and load.
    tbl[17] = mk(1, 4'b0010, MEM_SW,  32'hFFFF_FFF0, 32'h12345678, 4'b0010, MEM_NOP, 4'b0000, 0, 0);
    tbl[18] = mk(0, 4'b0010, MEM_LW,  32'hFFFF_FFF0, 0,   4'b0010, MEM_NOP, 4'b0010, 1, 0);
    tbl[19] = mk(0, 4'b0000, MEM_NOP, 0,       0,   4'b0000, MEM_NOP, 4'b0010, 1, 0);
    tbl[20] = mk(0, 4'b0000, MEM_NOP, 0,       0,   4'b0000, MEM_NOP, 4'b0000, 0, 0);
    // Two requesters starve together while the LSU is busy.
    tbl[21] = mk(1, 4'b1101, MEM_LW,  32'h100, 0,   4'b0001, MEM_LW,  4'b0000, 0, 0);
    tbl[22] = mk(0, 4'b1101, MEM_LW,  32'h100, 0,   4'b0001, MEM_LW,  4'b0001, 0, c_D);
    tbl[23] = mk(0, 4'b1101, MEM_LW,  32'h100, 0,   4'b0001, MEM_LW,  4'b0001, 0, c_D);
    tbl[24] = mk(0, 4'b1101, MEM_LW,  32'h100, 0,   4'b0001, MEM_LW,  4'b0001, 0, c_D);
    tbl[25] = mk(0, 4'b1101, MEM_LW,  32'h100, 0,   4'b0100, MEM_LW,  4'b0001, 0, c_D);
    tbl[26] = mk(0, 4'b1101, MEM_LW,  32'h100, 0,   4'b1000, MEM_LW,  4'b0100, 0, c_D);
    tbl[27] = mk(0, 4'b1101, MEM_LW,  32'h100, 0,   4'b0001, MEM_LW,  4'b1000, 0, c_D);
    tbl[28] = mk(0, 4'b0000, MEM_NOP, 0,       0,   4'b0000, MEM_NOP, 4'b0001, 0, c_D);

    for (int t = 0; t < 29; t++) begin
      @(posedge clk); #1;
      drive_all(tbl[t].valid, tbl[t].op, tbl[t].addr, tbl[t].data);
      if (tbl[t].rst) begin
        reset = 1'b1;
        #1;
        check($sformatf("v%0d in-reset grant", t), req_grant, 0);
        check($sformatf("v%0d in-reset rsp_valid", t), rsp_valid, 0);
        #1 reset = 1'b0;
      end
      @(negedge clk);
      check($sformatf("v%0d grant", t), req_grant, tbl[t].grant);
      check($sformatf("v%0d mem op", t), mem_request.op, tbl[t].mop);
      check($sformatf("v%0d rsp_valid", t), rsp_valid, tbl[t].rv);
      check($sformatf("v%0d rsp_err", t), rsp_err, tbl[t].re);
      check($sformatf("v%0d rsp_data", t), rsp_data, tbl[t].rd);
    end

    // Reset between a load grant and its response edge.
    @(posedge clk); #1;
    drive_all(4'b0100, MEM_SW, 32'h200, 32'hA5A50001);
    @(negedge clk);
    check("arst pre-store grant", req_grant, 4'b0100);
    @(posedge clk); #1;
    drive_all(4'b0010, MEM_LW, 32'h200, 32'd0);
    @(negedge clk);
    check("arst load grant", req_grant, 4'b0010);
    #2 reset = 1'b1;
    #1 check("arst grant during reset", req_grant, 0);
    check("arst mem op during reset", mem_request.op, MEM_NOP);
    @(posedge clk); #2;
    reset = 1'b0;
    drive_all(4'b0000, MEM_NOP, 32'd0, 32'd0);
    @(negedge clk);
    check("arst rsp_valid dropped", rsp_valid, 0);
    check("arst rsp_data", rsp_data, 0);
    @(posedge clk); #1;
    drive_all(4'b0110, MEM_LW, 32'h200, 32'd0);
    @(negedge clk);
    check("arst first grant", req_grant, 4'b0010);
    @(posedge clk); #1;
    drive_all(4'b0000, MEM_NOP, 32'd0, 32'd0);
    @(negedge clk);
    check("arst first rsp_valid", rsp_valid, 4'b0010);
    check("arst first rsp_data", rsp_data, 32'hA5A50001);

    // Randomized traffic against the reference model.
    @(posedge clk); #1;
    reset = 1'b1;
    #2 reset = 1'b0;
    for (int i = 0; i < c_N; i++) begin
      m_wait[i] = 0; hold[i] = 0; cur_v[i] = 0; cur_r[i] = '0;
    end
    m_rr = 0; prev_grant = '0; prev_err = 0; prev_rd = 0;

    for (int c = 0; c < 600; c++) begin
      int      g;
      bit      comp [c_N];
      bit      inr;
      mem_op_t eop;
      @(posedge clk); #1;
      for (int i = 0; i < c_N; i++) begin
        if (!hold[i] || $urandom_range(15) == 0) begin
          int r;
          cur_v[i] = ($urandom_range(99) < ((i == 0) ? 55 : 40));
          r = $urandom_range(9);
          cur_r[i].op   = (r == 0) ? MEM_NOP : (r < 6) ? MEM_LW : MEM_SW;
          cur_r[i].addr = ($urandom_range(7) == 0) ? (32'hFFFF_0000 | ($urandom & 32'h0000_FFFC))
                                                   : (32'h800 + 32'($urandom_range(511)) * 4);
          cur_r[i].data = $urandom;
          hold[i] = cur_v[i];
        end
        req_valid[i] = cur_v[i];
        req[i]       = cur_r[i];
        comp[i]      = cur_v[i] && (cur_r[i].op != MEM_NOP);
      end

      g = -1;
      for (int i = 1; i < c_N; i++) if (g < 0 && comp[i] && m_wait[i] >= c_MW) g = i;
      if (g < 0 && comp[0]) g = 0;
      for (int k = 1; k < c_N; k++) begin
        int cand;
        cand = ((m_rr + k - 1) % (c_N - 1)) + 1;
        if (g < 0 && comp[cand]) g = cand;
      end

      inr = (g >= 0) && (cur_r[(g < 0) ? 0 : g].addr < 32'h1000);
      eop = (g >= 0 && inr) ? cur_r[g].op : MEM_NOP;

      @(negedge clk);
      check($sformatf("r%0d grant", c), req_grant, (g >= 0) ? (32'd1 << g) : 32'd0);
      check($sformatf("r%0d mem op", c), mem_request.op, eop);
      check($sformatf("r%0d mem addr", c), mem_request.addr, (g >= 0) ? cur_r[g].addr : 32'd0);
      check($sformatf("r%0d mem data", c), mem_request.data, (g >= 0) ? cur_r[g].data : 32'd0);
      check($sformatf("r%0d rsp_valid", c), rsp_valid, prev_grant);
      check($sformatf("r%0d rsp_err", c), rsp_err, prev_err);
      check($sformatf("r%0d rsp_data", c), rsp_data, prev_rd);

      for (int i = 1; i < c_N; i++) begin
        if (comp[i] && g != i) m_wait[i] = (m_wait[i] < 15) ? m_wait[i] + 1 : 15;
        else                   m_wait[i] = 0;
      end
      if (g > 0) m_rr = g;
      prev_grant = (g >= 0) ? c_N'(1 << g) : '0;
      prev_err   = (g >= 0) && !inr;
      prev_rd    = 32'd0;
      if (g >= 0 && inr) begin
        int key;
        key = int'(cur_r[g].addr[31:2]);
        if (cur_r[g].op == MEM_LW) prev_rd = mm.exists(key) ? mm[key] : 32'd0;
        if (cur_r[g].op == MEM_SW) mm[key] = cur_r[g].data;
      end
      if (g >= 0) hold[g] = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
